serial_bus_arbiter: RTL and testbench

//  Central arbiter for the shared portBus/dataBus pair driven by the cores' communication units.

---
 rtl/serial_bus_arbiter.sv | 92 +++++++++
 tb/tb_serial_bus_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter: round-robin arbiter for a shared bus with guard gap and hold timeout
module serial_bus_arbiter #(
  parameter int N_CORES      = 4,
  parameter int IDX_W        = 2,
  parameter int GUARD_CYCLES = 2,
  parameter int MAX_HOLD     = 1024,
  parameter int HOLD_W       = 11
) (
  input  logic               medClk,
  input  logic               rst,
  input  logic [N_CORES-1:0] req,
  output logic [N_CORES-1:0] gnt,
  output logic [IDX_W-1:0]   owner,
  output logic               busy,
  output logic               timeout
);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GUARD = 2'd2;
  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d, owner_q, owner_d, sel, idx, nxt;
  logic [N_CORES-1:0] gnt_q, gnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [GW-1:0]      gcnt_q, gcnt_d;
  logic               timeout_q, timeout_d, expire;
  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = state_q != IDLE;
  assign timeout = timeout_q;
  assign nxt     = owner_q == IDX_W'(N_CORES - 1) ? '0 : owner_q + 1'b1;
  assign expire  = MAX_HOLD != 0 && hold_q == HOLD_W'(MAX_HOLD - 1);
  // first requester at or after the round-robin pointer; scanned backwards so the nearest wins
  always_comb begin
    sel = rr_q;
    idx = rr_q;
    for (int k = N_CORES - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(rr_q) + k) % N_CORES);
      if (req[idx]) sel = idx;
    end
  end
  // next-state logic: IDLE picks a winner, GRANT waits for release or timeout, GUARD pads the gap
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    gnt_d     = gnt_q;
    hold_d    = hold_q;
    gcnt_d    = gcnt_q;
    timeout_d = 1'b0;
    if (state_q == IDLE) begin
      if (|req) begin
        state_d = GRANT;
        owner_d = sel;
        gnt_d   = N_CORES'(1) << sel;
        hold_d  = '0;
      end
    end else if (state_q == GRANT) begin
      hold_d = hold_q == '1 ? hold_q : hold_q + 1'b1;
      if (!req[owner_q] || expire) begin
        state_d   = GUARD;
        gnt_d     = '0;
        rr_d      = nxt;
        gcnt_d    = '0;
        timeout_d = req[owner_q];
      end
    end else begin
      gcnt_d  = gcnt_q + 1'b1;
      state_d = gcnt_q == GW'(GUARD_CYCLES - 1) ? IDLE : state_q;
    end
  end
  // state registers with immediate asynchronous clear
  always_ff @(posedge medClk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      owner_q   <= '0;
      gnt_q     <= '0;
      hold_q    <= '0;
      gcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      hold_q    <= hold_d;
      gcnt_q    <= gcnt_d;
      timeout_q <= timeout_d;
    end
  end
endmodule

// File: tb/tb_serial_bus_arbiter.sv
// tb_serial_bus_arbiter: directed stimulus checked against a behavioural arbiter model
module tb_serial_bus_arbiter;
  localparam int N = 4, G = 2, MH = 8;
  logic       medClk = 1'b0;
  logic       rst;
  logic [3:0] req, gnt;
  logic [1:0] owner;
  logic       busy, timeout;
  int checks = 0, errors = 0;
  int cyc = 0, hi = 0, lo = 0, age = 0;
  int gq[$], gapq[$], runq[$], toq[$];
  int exp_order[5] = '{0, 1, 2, 3, 0};
  bit m_gnt, m_to;
  int m_own, m_ptr, m_held, m_guard;

  serial_bus_arbiter #(.N_CORES(4), .IDX_W(2), .GUARD_CYCLES(G), .MAX_HOLD(MH), .HOLD_W(4)) dut (
    .medClk(medClk), .rst(rst), .req(req), .gnt(gnt), .owner(owner), .busy(busy), .timeout(timeout)
  );

  always #5 medClk = ~medClk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge medClk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input logic [3:0] t, input string name);
    for (int i = 0; i < 12 && gnt != t; i++) tick();
    chk(name, int'(gnt), int'(t));
  endtask

  always @(posedge medClk) cyc++;

  // model: grant held until release or MH cycles, then G idle-busy cycles, then round-robin pick
  always @(posedge medClk or posedge rst) begin
    if (rst) begin
      m_gnt = 0; m_to = 0; m_own = 0; m_ptr = 0; m_held = 0; m_guard = 0;
    end else begin
      m_to = 0;
      if (m_gnt) begin
        m_held++;
        if (!req[m_own] || m_held == MH) begin
          m_to = req[m_own];
          m_gnt = 0;
          m_ptr = (m_own + 1) % N;
          m_guard = G;
        end
      end else if (m_guard > 0) m_guard--;
      else for (int k = 0; k < N; k++)
        if (!m_gnt && req[(m_ptr + k) % N]) begin
          m_own = (m_ptr + k) % N;
          m_gnt = 1;
          m_held = 0;
        end
    end
  end

  always @(negedge medClk) begin
    chk("gnt", int'(gnt), m_gnt ? (1 << m_own) : 0);
    chk("owner", int'(owner), m_own);
    chk("busy", int'(busy), int'(m_gnt || m_guard > 0));
    chk("timeout", int'(timeout), int'(m_to));
    chk("onehot", int'($countones(gnt) <= 1), 1);
    if (rst) begin
      hi = 0; lo = 0;
      gq.delete(); gapq.delete(); runq.delete(); toq.delete();
    end else begin
      if (gnt != 0) begin
        if (hi == 0) begin
          gq.push_back(int'(owner));
          gapq.push_back(lo);
        end
        hi++;
        lo = 0;
      end else begin
        if (hi > 0) runq.push_back(hi);
        hi = 0;
        lo++;
      end
      if (timeout) toq.push_back(cyc);
    end
  end

  initial begin
    rst = 1'b1;
    req = 4'b1111;
    repeat (3) begin
      tick();
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_owner", int'(owner), 0);
      chk("rst_timeout", int'(timeout), 0);
    end
    rst = 1'b0;
    req = 4'b0100;
    tick();
    chk("s2_gnt", int'(gnt), 4);
    chk("s2_owner", int'(owner), 2);
    repeat (4) tick();
    req = 4'b0000;
    tick();
    chk("s2_release", int'(gnt), 0);
    chk("s2_guard_busy", int'(busy), 1);
    repeat (2) tick();
    chk("s2_idle_busy", int'(busy), 0);

    do_reset();
    req = 4'b1111;
    age = 0;
    for (int i = 0; i < 80 && gq.size() < 5; i++) begin
      tick();
      if (gnt != 0) begin
        age++;
        req = age >= 2 ? ~gnt : 4'b1111;
      end else begin
        age = 0;
        req = 4'b1111;
      end
    end
    chk("s3_grants", int'(gq.size() >= 5), 1);
    if (gq.size() >= 5)
      for (int i = 0; i < 5; i++) begin
        chk("s3_order", gq[i], exp_order[i]);
        if (i > 0) chk("s3_gap", gapq[i], 3);
      end

    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 40 && toq.size() < 2; i++) tick();
    chk("s4_pulses", int'(toq.size() >= 2), 1);
    if (toq.size() >= 2 && gq.size() >= 2) begin
      chk("s4_period", toq[1] - toq[0], 11);
      chk("s4_hold_len", runq[0], 8);
      chk("s4_regrant_gap", gapq[1], 3);
      chk("s4_regrant_owner", gq[1], 1);
    end

    do_reset();
    req = 4'b1000;
    tick();
    chk("s5_gnt", int'(gnt), 8);
    req = 4'b1001;
    repeat (3) begin
      tick();
      chk("s5_hold", int'(gnt), 8);
    end
    req = 4'b0001;
    repeat (3) begin
      tick();
      chk("s5_low", int'(gnt), 0);
    end
    tick();
    chk("s5_next", int'(gnt), 1);

    req = 4'b0010;
    wait_gnt(4'b0010, "s6_grant1");
    req = 4'b0100;
    wait_gnt(4'b0100, "s6_grant2");
    rst = 1'b1;
    #1;
    chk("s6_async_gnt", int'(gnt), 0);
    chk("s6_async_busy", int'(busy), 0);
    chk("s6_async_timeout", int'(timeout), 0);
    #1;
    rst = 1'b0;
    req = 4'b0110;
    tick();
    chk("s6_rr_gnt", int'(gnt), 2);
    chk("s6_rr_owner", int'(owner), 1);
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
